// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing generator with a pixel request port.
// Produces hs/vs/de/rgb for an encoder stage from free-running h/v counters.
// Optional build macro TEST_PATTERN_EN swaps the upstream pixel for
// eight vertical colour bars.
//
// Pixel handshake: pix_req is a combinational request for coordinate
// (x_pos, y_pos). The upstream source must present that pixel on
// pix_data_in in the same cycle; it is captured at the next clock edge and
// appears on rgb together with de one cycle later. There is no back-pressure.
// The source cannot stall, and a missed pixel is simply lost.
`timescale 1ns/1ps
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic        pixel_clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [23:0] pix_data_in,
  output logic        pix_req,
  output logic [23:0] rgb,
  output logic        hs,
  output logic        vs,
  output logic        de,
  output logic        display_en,
  output logic [10:0] x_pos,
  output logic [10:0] y_pos,
  output logic        frame_start,
  output logic [1:0]  dbg_state
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_ACT_C  = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_S = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_E = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_ACT_C  = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYNC_S = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_E = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [10:0] h_cnt_q, h_cnt_d;
  logic [10:0] v_cnt_q, v_cnt_d;
  logic [23:0] rgb_q, rgb_d;
  logic        de_q, de_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        disp_q, disp_d;

  logic        counting;
  logic        frame_last;
  logic        h_in_sync;
  logic        v_in_sync;
  logic [23:0] pixel_src;

  assign counting   = (state_q != ST_IDLE);
  assign frame_last = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
  assign h_in_sync  = (h_cnt_q >= H_SYNC_S) && (h_cnt_q < H_SYNC_E);
  assign v_in_sync  = (v_cnt_q >= V_SYNC_S) && (v_cnt_q < V_SYNC_E);

  // Request is a pure function of the counters so the upstream sees it a full cycle before de.
  assign pix_req     = counting && (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
  assign frame_start = pix_req && (h_cnt_q == 11'd0) && (v_cnt_q == 11'd0);
  assign x_pos       = h_cnt_q;
  assign y_pos       = v_cnt_q;

  assign rgb        = rgb_q;
  assign de         = de_q;
  assign hs         = hs_q;
  assign vs         = vs_q;
  assign display_en = disp_q;
  assign dbg_state  = state_q;

`ifdef TEST_PATTERN_EN
  localparam int          BAR_W_I = (H_ACTIVE / 8 > 0) ? (H_ACTIVE / 8) : 1;
  localparam logic [10:0] BAR_W   = 11'(BAR_W_I);
  logic [10:0] bar_idx;

  // Colour bar lookup; anything past the eighth bar stays black.
  always_comb begin
    bar_idx = h_cnt_q / BAR_W;
    case (bar_idx)
      11'd0:   pixel_src = 24'hFFFFFF;
      11'd1:   pixel_src = 24'hFFFF00;
      11'd2:   pixel_src = 24'h00FFFF;
      11'd3:   pixel_src = 24'h00FF00;
      11'd4:   pixel_src = 24'hFF00FF;
      11'd5:   pixel_src = 24'hFF0000;
      11'd6:   pixel_src = 24'h0000FF;
      default: pixel_src = 24'h000000;
    endcase
  end
`else
  assign pixel_src = pix_data_in;
`endif

  // FSM next state: DRAIN finishes the current frame unless enable comes back first.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (enable) state_d = ST_RUN;
      ST_RUN:   if (!enable) state_d = frame_last ? ST_IDLE : ST_DRAIN;
      ST_DRAIN: begin
        if (enable)          state_d = ST_RUN;
        else if (frame_last) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Raster counters advance in RUN and DRAIN and are parked at 0,0 in IDLE.
  always_comb begin
    h_cnt_d = 11'd0;
    v_cnt_d = 11'd0;
    if (counting) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = 11'd0;
        v_cnt_d = (v_cnt_q == V_LAST) ? 11'd0 : v_cnt_q + 11'd1;
      end else begin
        h_cnt_d = h_cnt_q + 11'd1;
        v_cnt_d = v_cnt_q;
      end
    end
  end

  // Output pipeline stage: everything the encoder sees lags the request by one cycle.
  always_comb begin
    rgb_d  = pix_req ? pixel_src : 24'h0;
    de_d   = pix_req;
    hs_d   = (counting && h_in_sync) ? HS_POL : ~HS_POL;
    vs_d   = (counting && v_in_sync) ? VS_POL : ~VS_POL;
    disp_d = counting;
  end

  // State, counter and output registers; reset abandons any frame in progress.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      h_cnt_q <= 11'd0;
      v_cnt_q <= 11'd0;
      rgb_q   <= 24'h0;
      de_q    <= 1'b0;
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
      disp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      rgb_q   <= rgb_d;
      de_q    <= de_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      disp_q  <= disp_d;
    end
  end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640: active pixels per line.
REQ-002 SHALL have parameter H_FP, default 16: horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96: horizontal sync width in pixels.
REQ-004 SHALL have parameter H_BP, default 48: horizontal back porch in pixels.
REQ-005 SHALL have parameter V_ACTIVE, default 480: active lines per frame.
REQ-006 SHALL have parameters V_FP, V_SYNC and V_BP, defaults 10, 2 and 33: vertical porches and sync, in lines.
REQ-007 SHALL have parameters HS_POL and VS_POL, default 0: active sync level (0 = active-low).
REQ-008 SHALL have port pixel_clk, input, 1 bit: the single clock.
REQ-009 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-010 SHALL have port enable, input, 1 bit: run request.
REQ-011 SHALL have port pix_data_in, input, 24 bits: upstream pixel, {R,G,B}.
REQ-012 SHALL have port pix_req, output, 1 bit: pixel request, one cycle ahead of de.
REQ-013 SHALL have ports rgb (output, 24 bits), hs, vs and de (outputs, 1 bit each): feed the encoder stage.
REQ-014 SHALL have port display_en, output, 1 bit: high while frames are generated.
REQ-015 SHALL have ports x_pos (output, 11 bits) and y_pos (output, 11 bits): coordinate of the pixel requested by pix_req.
REQ-016 SHALL have port frame_start, output, 1 bit: one-cycle pulse with the first pix_req of a frame.

Function
REQ-017 SHALL define H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL likewise.
REQ-018 SHALL count h_cnt from 0 to H_TOTAL-1 and then wrap to 0, incrementing v_cnt.
REQ-019 SHALL wrap v_cnt from V_TOTAL-1 to 0 simultaneously with the h_cnt wrap.
REQ-020 SHALL order the regions in each line and frame as active, front porch, sync, then back porch, starting at count 0.
REQ-021 SHALL implement a three-state FSM: IDLE, RUN and DRAIN.
REQ-022 SHALL leave IDLE for RUN when enable=1, with counters at 0,0.
REQ-023 SHALL go from RUN to DRAIN when enable=0 and h_cnt,v_cnt are not at the last count of the frame.
REQ-024 SHALL go from RUN directly to IDLE when enable=0 at the last count of the frame (H_TOTAL-1, V_TOTAL-1).
REQ-025 SHALL go from DRAIN to IDLE at the last count of the frame; enable reasserted during DRAIN SHALL return the FSM to RUN with no interruption of the counters.
REQ-026 SHALL in IDLE hold counters at 0 and drive de, pix_req and frame_start to 0, with hs/vs at their inactive levels.
REQ-027 SHALL assert pix_req combinationally from the counters when the FSM is in RUN or DRAIN, h_cnt<H_ACTIVE and v_cnt<V_ACTIVE; x_pos=h_cnt and y_pos=v_cnt.
REQ-028 SHALL register rgb, de, hs and vs, so de equals pix_req delayed by exactly 1 cycle.
REQ-029 SHALL sample pix_data_in on a pix_req cycle and present it on rgb in the following cycle (the de cycle).
REQ-030 SHALL drive rgb=0 whenever de=0.
REQ-031 SHALL delay hs and vs by the same 1 cycle so they stay aligned with de.
REQ-032 SHALL drive hs=HS_POL while h_cnt is in the horizontal sync region; vs SHALL be driven the same way from v_cnt and VS_POL.
REQ-033 SHALL drive display_en=1 one cycle after IDLE is left and 0 one cycle after IDLE is re-entered.
REQ-034 SHALL pulse frame_start for 1 cycle when h_cnt=0, v_cnt=0 and pix_req=1.
REQ-035 SHALL keep each counter width at 11 bits; parameter totals above 2047 are unsupported.

Reset
REQ-036 SHALL, on rst_n=0, immediately force: FSM to IDLE, counters to 0, rgb to 0, de/pix_req/frame_start/display_en to 0, hs to ~HS_POL and vs to ~VS_POL.
REQ-037 SHALL abandon any frame in progress on a reset mid-frame, with no DRAIN; reset release SHALL be synchronous to pixel_clk.

Configuration
REQ-038 SHALL, when macro TEST_PATTERN_EN is defined, replace pix_data_in with 8 vertical colour bars, each H_ACTIVE/8 pixels wide, in this order: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000; pix_req SHALL still be driven.
REQ-039 SHALL, without TEST_PATTERN_EN, pass pix_data_in as specified in REQ-029.

Verification
REQ-040 SHALL cover: reset release then enable=1 -> first de after 1 cycle, frame_start pulse, H_TOTAL=800 and V_TOTAL=525 cycles/lines between frame_start pulses.
REQ-041 SHALL cover: active line -> de high for exactly 640 cycles; hs low for 96 cycles starting 16 cycles after de falls; vs low for 2 lines.
REQ-042 SHALL cover: pix_data_in = {y_pos[7:0], x_pos[7:0], 8'hA5} -> rgb at x=5,y=3 is 03_05_A5 on the cycle after the request.
REQ-043 SHALL cover: enable dropped at line 100 -> frame completes, display_en falls after cycle (799,524); re-enable during DRAIN -> no gap between frames.
REQ-044 SHALL cover: rst_n asserted mid-active line -> same-cycle rgb=0, de=0, hs=1, vs=1, display_en=0.
REQ-045 SHALL cover: TEST_PATTERN_EN defined -> rgb=FFFFFF at x=0, FFFF00 at x=80, 000000 at x=639.
